disp_scheduler: RTL and testbench

//   Time-shares one 4-digit signed-decimal 7-segment display between up to

---
 rtl/disp_scheduler.sv | 92 +++++++++
 tb/tb_disp_scheduler.sv | 137 +++++++++++++
 2 files changed

// File: rtl/disp_scheduler.sv
// Round-robin time-sharing of one signed 8-bit display channel among four requesters.
// Each granted source is shown for DWELL cycles; an owner dropping its request yields immediately.
module disp_scheduler #(
    parameter int DWELL = 50_000_000,
    parameter int CW    = 26
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [31:0] data,
    input  logic        hold,
    output logic [7:0]  x_out,
    output logic        en_out,
    output logic [3:0]  grant,
    output logic        done
);

    localparam logic [0:0]    IDLE = 1'b0;
    localparam logic [0:0]    SHOW = 1'b1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [0:0]    state;
    logic [1:0]    ptr;
    logic [1:0]    owner;
    logic [CW-1:0] cnt;
    logic [1:0]    base;
    logic [1:0]    next_idx;
    logic          next_found;

    // Search base+1, base+2, base+3, base (mod 4); base itself comes last so a lone owner is re-granted.
    always_comb begin
        base       = (state == IDLE) ? ptr : owner;
        next_idx   = base;
        next_found = 1'b0;
        for (int k = 4; k >= 1; k--) begin
            if (req[2'(base + 2'(k))]) begin
                next_idx   = 2'(base + 2'(k));
                next_found = 1'b1;
            end
        end
    end

    assign grant  = (state == SHOW) ? (4'b0001 << owner) : 4'b0000;
    assign en_out = (state == SHOW);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= 2'd3;
            owner <= 2'd0;
            cnt   <= '0;
            done  <= 1'b0;
            x_out <= 8'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (next_found) begin
                        state <= SHOW;
                        owner <= next_idx;
                        cnt   <= '0;
                        x_out <= data[8*next_idx +: 8];
                    end
                end
                default: begin
                    // A vanished owner wins over dwell expiry and is never blocked by hold.
                    if (!req[owner]) begin
                        cnt <= '0;
                        if (next_found) begin
                            owner <= next_idx;
                            x_out <= data[8*next_idx +: 8];
                        end else begin
                            state <= IDLE;
                        end
                    end else if (!hold && cnt == LAST) begin
                        done  <= 1'b1;
                        ptr   <= owner;
                        cnt   <= '0;
                        owner <= next_idx;
                        x_out <= data[8*next_idx +: 8];
                    end else begin
                        x_out <= data[8*owner +: 8];
                        if (!hold) begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_disp_scheduler.sv
// Directed bench for disp_scheduler with DWELL=4; inputs change and outputs are sampled on the falling edge.
module tb_disp_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] data;
    logic        hold;
    logic [7:0]  x_out;
    logic        en_out;
    logic [3:0]  grant;
    logic        done;

    int evaluated = 0;
    int failures  = 0;

    disp_scheduler #(.DWELL(4), .CW(3)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .data   (data),
        .hold   (hold),
        .x_out  (x_out),
        .en_out (en_out),
        .grant  (grant),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        evaluated++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic [3:0] eg, input logic ed, input logic [7:0] ex);
        checkOutput({tag, ".grant"}, 32'(grant), 32'(eg));
        checkOutput({tag, ".en"}, 32'(en_out), 32'(eg != 4'b0000));
        checkOutput({tag, ".done"}, 32'(done), 32'(ed));
        checkOutput({tag, ".x"}, 32'(x_out), 32'(ex));
    endtask

    task automatic applyStimulus(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [7:0] bytes [4];

    initial begin
        bytes[0] = 8'h80; bytes[1] = 8'h00; bytes[2] = 8'hFF; bytes[3] = 8'h7F;
        reset = 1'b1;
        req   = 4'hF;
        data  = {8'h7F, 8'hFF, 8'h00, 8'h80};
        hold  = 1'b0;

        // Reset held with everyone requesting.
        applyStimulus(3);
        checkAll("reset", 4'b0000, 1'b0, 8'h00);
        reset = 1'b0;
        applyStimulus(1);
        checkAll("first", 4'b0001, 1'b0, 8'h80);

        // Full rotation, four cycles per grant, done on every handover.
        for (int g = 0; g < 5; g++) begin
            if (g != 0) checkAll($sformatf("rot%0d.start", g), 4'b0001 << (g % 4), 1'b1, bytes[g % 4]);
            for (int j = 1; j < 4; j++) begin
                applyStimulus(1);
                checkAll($sformatf("rot%0d.c%0d", g, j), 4'b0001 << (g % 4), 1'b0, bytes[g % 4]);
            end
            applyStimulus(1);
        end
        checkAll("rot5.start", 4'b0010, 1'b1, 8'h00);

        // Single requester: owner 1 drops, source 2 takes over and is re-granted each dwell.
        req = 4'b0100;
        applyStimulus(1);
        checkAll("solo.start", 4'b0100, 1'b0, 8'hFF);
        for (int r = 0; r < 2; r++) begin
            for (int j = 1; j < 4; j++) begin
                applyStimulus(1);
                checkAll($sformatf("solo%0d.c%0d", r, j), 4'b0100, 1'b0, 8'hFF);
            end
            applyStimulus(1);
            checkAll($sformatf("solo%0d.wrap", r), 4'b0100, 1'b1, 8'hFF);
        end

        // Owner drop mid-dwell, then everyone drops.
        req = 4'b0001;
        applyStimulus(1);
        checkAll("drop.own0", 4'b0001, 1'b0, 8'h80);
        req = 4'b1001;
        applyStimulus(2);
        checkAll("drop.cnt2", 4'b0001, 1'b0, 8'h80);
        req = 4'b1000;
        applyStimulus(1);
        checkAll("drop.to3", 4'b1000, 1'b0, 8'h7F);
        req = 4'b0000;
        applyStimulus(1);
        checkAll("drop.idle", 4'b0000, 1'b0, 8'h7F);
        applyStimulus(1);
        checkAll("idle.stay", 4'b0000, 1'b0, 8'h7F);

        // Hold freezes the dwell count while data keeps flowing.
        req = 4'b0001;
        applyStimulus(1);
        checkAll("hold.grant", 4'b0001, 1'b0, 8'h80);
        applyStimulus(1);
        hold = 1'b1;
        for (int j = 0; j < 10; j++) begin
            applyStimulus(1);
            if (j == 3) data = {8'h7F, 8'hFF, 8'h00, 8'h05};
            checkAll($sformatf("hold%0d", j), 4'b0001, 1'b0, (j >= 4) ? 8'h05 : 8'h80);
        end
        hold = 1'b0;
        applyStimulus(2);
        checkAll("resume.c3", 4'b0001, 1'b0, 8'h05);
        applyStimulus(1);
        checkAll("resume.done", 4'b0001, 1'b1, 8'h05);

        // Reset mid-SHOW restores source-0 priority.
        applyStimulus(2);
        reset = 1'b1;
        applyStimulus(1);
        checkAll("rst2.held", 4'b0000, 1'b0, 8'h00);
        reset = 1'b0;
        req   = 4'hF;
        applyStimulus(1);
        checkAll("rst2.first", 4'b0001, 1'b0, 8'h05);

        $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
        $finish;
    end

endmodule
